enemy_sprite_drawer: RTL and testbench

- Downstream consumer of the enemy datapath's `x_out`, `y_out`, `move` and `attack_out`, plus the controller's `dead`.
- On each move request it erases the enemy's previous rectangle with the background colour, then draws the rectangle at the new position in a state-dependent colour.
- Emits one pixel per cycle to the VGA adapter (`vga_x`, `vga_y`, `colour`, `plot`) on the 160x120 frame.

---
 rtl/enemy_pkg.sv | 24 ++
 rtl/enemy_sprite_drawer_box_scanner.sv | 44 ++++
 rtl/enemy_sprite_drawer.sv | 178 +++++++++++++++++
 tb/tb_enemy_sprite_drawer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared constants for the enemy sprite path: frame size, palette, drawer
// state encoding and the x_pos-to-pixel column mapping used by the datapath.
package enemy_pkg;

  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;
  localparam int unsigned SPR_W = 20;
  localparam int unsigned SPR_H = 30;

  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_BODY   = 3'b100;
  localparam logic [2:0] COL_ATTACK = 3'b110;
  localparam logic [2:0] COL_DEAD   = 3'b010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] XPIX_LEFT  = 8'd20;
  localparam logic [7:0] XPIX_MID   = 8'd60;
  localparam logic [7:0] XPIX_RIGHT = 8'd100;

endpackage

// File: rtl/enemy_sprite_drawer_box_scanner.sv
// Row-major col/row walker over a W x H box; reused for erase and draw passes.
module box_scanner #(
  parameter int unsigned W = 20,
  parameter int unsigned H = 30
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_advance,
  output logic [$clog2(W)-1:0] o_col,
  output logic [$clog2(H)-1:0] o_row,
  output logic                 o_last
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(H);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/enemy_sprite_drawer.sv
// Erases the enemy's previous box, then draws the new one, one registered
// pixel per cycle; one move request may queue while a pass is in flight.
module enemy_sprite_drawer
  import enemy_pkg::*;
#(
  parameter int unsigned SPRITE_W      = SPR_W,
  parameter int unsigned SPRITE_H      = SPR_H,
  parameter int unsigned SCREEN_W      = SCR_W,
  parameter int unsigned SCREEN_H      = SCR_H,
  parameter logic [2:0]  BG_COLOUR     = COL_BG,
  parameter logic [2:0]  BODY_COLOUR   = COL_BODY,
  parameter logic [2:0]  ATTACK_COLOUR = COL_ATTACK,
  parameter logic [2:0]  DEAD_COLOUR   = COL_DEAD
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic       attack_in,
  input  logic       dead_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(SPRITE_W);
  localparam int unsigned RW = $clog2(SPRITE_H);

  logic [1:0] r_state;
  logic       r_have_old;
  logic       r_pending;
  logic [7:0] r_old_x, r_new_x, r_pend_x;
  logic [6:0] r_old_y, r_new_y, r_pend_y;
  logic       r_new_attack, r_new_dead, r_pend_attack, r_pend_dead;

  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_colour;
  logic       r_plot, r_busy, r_done;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last;
  logic          w_active;
  logic [7:0]    w_base_x;
  logic [6:0]    w_base_y;
  logic [8:0]    w_sum_x;
  logic [7:0]    w_sum_y;
  logic          w_visible;
  logic [2:0]    w_colour;

  assign w_active = (r_state == ST_ERASE) || (r_state == ST_DRAW);

  box_scanner #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_scan (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_clear   (!w_active || w_last),
    .i_advance (w_active),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_last    (w_last)
  );

  always_comb begin
    w_base_x = r_new_x;
    w_base_y = r_new_y;
    w_colour = BODY_COLOUR;
    if (r_state == ST_ERASE) begin
      w_base_x = r_old_x;
      w_base_y = r_old_y;
      w_colour = BG_COLOUR;
    end else if (r_new_dead) begin
      w_colour = DEAD_COLOUR;
    end else if (r_new_attack) begin
      w_colour = ATTACK_COLOUR;
    end
  end

  assign w_sum_x   = {1'b0, w_base_x} + 9'(w_col);
  assign w_sum_y   = {1'b0, w_base_y} + 8'(w_row);
  assign w_visible = (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_have_old    <= 1'b0;
      r_pending     <= 1'b0;
      r_old_x       <= '0;
      r_old_y       <= '0;
      r_new_x       <= '0;
      r_new_y       <= '0;
      r_new_attack  <= 1'b0;
      r_new_dead    <= 1'b0;
      r_pend_x      <= '0;
      r_pend_y      <= '0;
      r_pend_attack <= 1'b0;
      r_pend_dead   <= 1'b0;
    end else begin
      if (start && w_active) begin
        r_pending     <= 1'b1;
        r_pend_x      <= x_in;
        r_pend_y      <= y_in;
        r_pend_attack <= attack_in;
        r_pend_dead   <= dead_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_new_x      <= x_in;
            r_new_y      <= y_in;
            r_new_attack <= attack_in;
            r_new_dead   <= dead_in;
            r_state      <= r_have_old ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: if (w_last) r_state <= ST_DRAW;
        ST_DRAW:  if (w_last) r_state <= ST_DONE;
        ST_DONE: begin
          r_old_x    <= r_new_x;
          r_old_y    <= r_new_y;
          r_have_old <= 1'b1;
          r_pending  <= 1'b0;
          // A start seen in DONE is newer than any queued one, so it is loaded
          // directly instead of passing through the pending registers.
          if (start) begin
            r_new_x      <= x_in;
            r_new_y      <= y_in;
            r_new_attack <= attack_in;
            r_new_dead   <= dead_in;
            r_state      <= ST_ERASE;
          end else if (r_pending) begin
            r_new_x      <= r_pend_x;
            r_new_y      <= r_pend_y;
            r_new_attack <= r_pend_attack;
            r_new_dead   <= r_pend_dead;
            r_state      <= ST_ERASE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_vga_x  <= w_active ? w_sum_x[7:0] : '0;
      r_vga_y  <= w_active ? w_sum_y[6:0] : '0;
      r_colour <= w_active ? w_colour : '0;
      r_plot   <= w_active && w_visible;
      r_busy   <= w_active;
      r_done   <= (r_state == ST_DONE);
    end
  end

  assign vga_x  = r_vga_x;
  assign vga_y  = r_vga_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_enemy_sprite_drawer.sv
// Directed bench for enemy_sprite_drawer: table of single requests plus
// hand sequences for queued starts, start-in-DONE and reset mid-erase.
module tb_enemy_sprite_drawer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic       attack_in = 1'b0;
  logic       dead_in = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #5 clock = ~clock;

  enemy_sprite_drawer #(
    .SPRITE_W (20),
    .SPRITE_H (30),
    .SCREEN_W (160),
    .SCREEN_H (120)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .attack_in (attack_in),
    .dead_in   (dead_in),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    bit         rst;
    logic [7:0] x;
    logic [6:0] y;
    logic       a;
    logic       d;
    int         lat;
    int         nbg;
    int         nfg;
    logic [2:0] col;
    int         fx0, fy0, fx1, fy1;
    int         bminx, bmaxx, bminy, bmaxy;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  int s_bg, s_fg, s_colerr, s_nobusy, s_ndone;
  int s_done_at [2];
  int fg_minx, fg_maxx, bg_minx, bg_maxx, bg_miny, bg_maxy;
  int first_fx, first_fy, last_fx, last_fy;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pix", int'({vga_x, vga_y, colour}), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Issues one request and watches outputs #1 after each edge until ndone
  // done pulses or the budget expires; optional extra starts at given cycles.
  task automatic run_req(input logic [7:0] x, input logic [6:0] y,
                         input logic a, input logic d, input logic [2:0] expc,
                         input int inj1, input logic [7:0] ix1,
                         input int inj2, input logic [7:0] ix2,
                         input int ndone, input int budget);
    int cyc;
    s_bg = 0; s_fg = 0; s_colerr = 0; s_nobusy = 0; s_ndone = 0;
    s_done_at[0] = -1; s_done_at[1] = -1;
    fg_minx = 999; fg_maxx = -1;
    bg_minx = 999; bg_maxx = -1; bg_miny = 999; bg_maxy = -1;
    first_fx = -1; first_fy = -1; last_fx = -1; last_fy = -1;
    x_in = x; y_in = y; attack_in = a; dead_in = d;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 0;
    while (s_ndone < ndone && cyc < budget) begin
      @(posedge clock);
      cyc++;
      #1;
      if (start) start = 1'b0;
      if (cyc == inj1) begin
        start = 1'b1; x_in = ix1; attack_in = 1'b0; dead_in = 1'b0;
      end
      if (cyc == inj2) begin
        start = 1'b1; x_in = ix2; attack_in = 1'b0; dead_in = 1'b0;
      end
      if (plot) begin
        if (!busy) s_nobusy++;
        if (colour == 3'b000) begin
          s_bg++;
          if (int'(vga_x) < bg_minx) bg_minx = int'(vga_x);
          if (int'(vga_x) > bg_maxx) bg_maxx = int'(vga_x);
          if (int'(vga_y) < bg_miny) bg_miny = int'(vga_y);
          if (int'(vga_y) > bg_maxy) bg_maxy = int'(vga_y);
        end else begin
          s_fg++;
          if (colour != expc) s_colerr++;
          if (int'(vga_x) < fg_minx) fg_minx = int'(vga_x);
          if (int'(vga_x) > fg_maxx) fg_maxx = int'(vga_x);
          if (first_fx < 0) begin
            first_fx = int'(vga_x);
            first_fy = int'(vga_y);
          end
          last_fx = int'(vga_x);
          last_fy = int'(vga_y);
        end
      end
      if (done) begin
        if (s_ndone < 2) s_done_at[s_ndone] = cyc;
        s_ndone++;
      end
    end
    start = 1'b0;
    chk("done_count", s_ndone, ndone);
    chk("plot_without_busy", s_nobusy, 0);
  endtask

  vec_t vt [4];

  initial begin
    vt[0] = '{1'b1, 8'd20,  7'd8,   1'b0, 1'b0, 601,  0,   600, 3'b100,
              20, 8, 39, 37, 0, 0, 0, 0};
    vt[1] = '{1'b0, 8'd60,  7'd8,   1'b1, 1'b0, 1201, 600, 600, 3'b110,
              60, 8, 79, 37, 20, 39, 8, 37};
    vt[2] = '{1'b1, 8'd150, 7'd100, 1'b0, 1'b0, 601,  0,   200, 3'b100,
              150, 100, 159, 119, 0, 0, 0, 0};
    vt[3] = '{1'b0, 8'd20,  7'd50,  1'b1, 1'b1, 1201, 200, 600, 3'b010,
              20, 50, 39, 79, 150, 159, 100, 119};

    for (int i = 0; i < 4; i++) begin
      if (vt[i].rst) apply_reset();
      run_req(vt[i].x, vt[i].y, vt[i].a, vt[i].d, vt[i].col,
              0, 8'd0, 0, 8'd0, 1, 3000);
      chk($sformatf("v%0d_latency", i), s_done_at[0], vt[i].lat);
      chk($sformatf("v%0d_bg_pixels", i), s_bg, vt[i].nbg);
      chk($sformatf("v%0d_fg_pixels", i), s_fg, vt[i].nfg);
      chk($sformatf("v%0d_colour_errs", i), s_colerr, 0);
      chk($sformatf("v%0d_first_x", i), first_fx, vt[i].fx0);
      chk($sformatf("v%0d_first_y", i), first_fy, vt[i].fy0);
      chk($sformatf("v%0d_last_x", i), last_fx, vt[i].fx1);
      chk($sformatf("v%0d_last_y", i), last_fy, vt[i].fy1);
      chk($sformatf("v%0d_fg_minx", i), fg_minx, vt[i].fx0);
      chk($sformatf("v%0d_fg_maxx", i), fg_maxx, vt[i].fx1);
      if (vt[i].nbg > 0) begin
        chk($sformatf("v%0d_bg_minx", i), bg_minx, vt[i].bminx);
        chk($sformatf("v%0d_bg_maxx", i), bg_maxx, vt[i].bmaxx);
        chk($sformatf("v%0d_bg_miny", i), bg_miny, vt[i].bminy);
        chk($sformatf("v%0d_bg_maxy", i), bg_maxy, vt[i].bmaxy);
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_done_width", i), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
    end

    // Two starts during the first draw: only the latest (x=20) survives.
    apply_reset();
    run_req(8'd20, 7'd8, 1'b0, 1'b0, 3'b100, 11, 8'd100, 51, 8'd20, 2, 3000);
    chk("q_done0", s_done_at[0], 601);
    chk("q_done1", s_done_at[1], 1802);
    chk("q_fg_pixels", s_fg, 1200);
    chk("q_fg_minx", fg_minx, 20);
    chk("q_fg_maxx", fg_maxx, 39);
    chk("q_bg_pixels", s_bg, 600);
    chk("q_bg_maxx", bg_maxx, 39);

    // Start arriving while the drawer sits in DONE.
    apply_reset();
    run_req(8'd20, 7'd8, 1'b0, 1'b0, 3'b100, 600, 8'd60, 0, 8'd0, 2, 3000);
    chk("dn_done0", s_done_at[0], 601);
    chk("dn_done1", s_done_at[1], 1802);
    chk("dn_fg_pixels", s_fg, 1200);
    chk("dn_fg_maxx", fg_maxx, 79);
    chk("dn_bg_pixels", s_bg, 600);
    chk("dn_bg_minx", bg_minx, 20);
    chk("dn_bg_maxx", bg_maxx, 39);

    // Reset in the middle of erasing the box at x=60.
    x_in = 8'd20; y_in = 7'd8; attack_in = 1'b0; dead_in = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    chk("mid_busy", int'(busy), 1);
    chk("mid_plot", int'(plot), 1);
    chk("mid_erase_colour", int'(colour), 0);
    chk("mid_erase_x_hi", int'(vga_x >= 8'd60 && vga_x <= 8'd79), 1);
    reset_n = 1'b0;
    #1;
    chk("async_plot", int'(plot), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_x", int'(vga_x), 0);
    chk("async_y", int'(vga_y), 0);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_req(8'd60, 7'd8, 1'b0, 1'b0, 3'b100, 0, 8'd0, 0, 8'd0, 1, 3000);
    chk("post_rst_latency", s_done_at[0], 601);
    chk("post_rst_bg", s_bg, 0);
    chk("post_rst_fg", s_fg, 600);
    chk("post_rst_minx", fg_minx, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
